// File: rtl/binary_bcd_seq.sv
// Sequential binary-to-BCD converter: shift-add-3 (double dabble), one input bit per clock.
// Produces a zero-padded BCD result plus a leading-zero blanking mask for display drivers.
module binary_bcd_seq #(
  parameter int BIN_W = 20,
  parameter int DIG_N = 7
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin_in,
  output logic               busy,
  output logic               done,
  output logic [4*DIG_N-1:0] bcd_out,
  output logic [DIG_N-1:0]   blank
);

  // Decimal digits needed to hold 2^w - 1, i.e. ceil(w*log10(2)).
  function automatic int min_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        n++;
        v = v / 10;
      end
    end
    return (n == 0) ? 1 : n;
  endfunction

  if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
    $error("binary_bcd_seq: BIN_W must be in 4..32");
  end
  if (DIG_N < min_digits(BIN_W)) begin : g_bad_dig_n
    $error("binary_bcd_seq: DIG_N too small for BIN_W");
  end

  localparam int                 CNT_W     = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(BIN_W - 1);
  localparam logic [DIG_N-1:0]   BLANK_RST = ~DIG_N'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [BIN_W-1:0]     r_bin;
  logic [4*DIG_N-1:0]   r_scratch;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [4*DIG_N-1:0]   r_bcd;
  logic [DIG_N-1:0]     r_blank;

  logic [4*DIG_N-1:0]   w_adj;
  logic [4*DIG_N-1:0]   w_shifted;
  logic [DIG_N-1:0]     w_blank;

  genvar gi;
  generate
    for (gi = 0; gi < DIG_N; gi++) begin : g_dig
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                r_scratch[4*gi +: 4] + 4'd3 : r_scratch[4*gi +: 4];
      // A digit is blankable when it and every more significant digit are zero; ones never blanks.
      if (gi == 0) begin : g_ones
        assign w_blank[gi] = 1'b0;
      end else begin : g_upper
        assign w_blank[gi] = (r_scratch[4*DIG_N-1:4*gi] == '0);
      end
    end
  endgenerate

  assign w_shifted = {w_adj[4*DIG_N-2:0], r_bin[BIN_W-1]};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_blank   <= BLANK_RST;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin     <= bin_in;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_shifted;
          r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt     <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_bcd   <= r_scratch;
          r_blank <= w_blank;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign bcd_out = r_bcd;
  assign blank   = r_blank;

endmodule

// File: tb/tb_binary_bcd_seq.sv
// Self-checking bench for binary_bcd_seq: an 8/3 instance for detailed timing and exhaustive
// checks, and a default 20/7 instance for wide values; reference built from decimal arithmetic.
module tb_binary_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        s8;
  logic [7:0]  b8;
  logic        busy8, done8;
  logic [11:0] bcd8;
  logic [2:0]  blank8;

  logic        s20;
  logic [19:0] b20;
  logic        busy20, done20;
  logic [27:0] bcd20;
  logic [6:0]  blank20;

  int          errors = 0;
  int          checks = 0;
  logic [11:0] prev_bcd8;

  always #5 clk = ~clk;

  binary_bcd_seq #(.BIN_W(8), .DIG_N(3)) u_dut8 (
    .sys_clk (clk),
    .sys_rst (rst),
    .start   (s8),
    .bin_in  (b8),
    .busy    (busy8),
    .done    (done8),
    .bcd_out (bcd8),
    .blank   (blank8)
  );

  binary_bcd_seq u_dut20 (
    .sys_clk (clk),
    .sys_rst (rst),
    .start   (s20),
    .bin_in  (b20),
    .busy    (busy20),
    .done    (done20),
    .bcd_out (bcd20),
    .blank   (blank20)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Decimal digits of v, zero padded to n digits, one nibble per digit.
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int n);
    logic [63:0]     r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Digit i (i >= 1) is a leading zero exactly when v < 10^i.
  function automatic logic [63:0] ref_blank(input longint unsigned v, input int n);
    logic [63:0]     m;
    longint unsigned p;
    m = '0;
    p = 10;
    for (int i = 1; i < n; i++) begin
      if (v < p) m[i] = 1'b1;
      p = p * 10;
    end
    return m;
  endfunction

  // One 8-bit conversion; returns in the done cycle so the next call runs back to back.
  task automatic conv8(input logic [7:0] v, input string tag);
    int          cyc;
    int          busy_n;
    bit          got;
    logic [63:0] eb;
    logic [63:0] em;
    cyc    = 0;
    busy_n = 0;
    got    = 0;
    eb     = ref_bcd(longint'(v), 3);
    em     = ref_blank(longint'(v), 3);
    s8 = 1'b1;
    b8 = v;
    @(posedge clk); #1;
    s8 = 1'b0;
    b8 = 8'($urandom);
    if (busy8) busy_n++;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (busy8) busy_n++;
      if (done8) got = 1;
      else check({tag, " hold"}, 64'(bcd8), 64'(prev_bcd8));
    end
    check({tag, " latency"}, 64'(cyc), 64'd9);
    check({tag, " bcd"}, 64'(bcd8), eb);
    check({tag, " blank"}, 64'(blank8), em);
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd9);
    $display("conv8 %s in=%0d bcd=%03h blank=%03b latency=%0d", tag, v, bcd8, blank8, cyc);
    prev_bcd8 = eb[11:0];
  endtask

  task automatic conv20(input logic [19:0] v, input string tag);
    int cyc;
    cyc = 0;
    s20 = 1'b1;
    b20 = v;
    @(posedge clk); #1;
    s20 = 1'b0;
    b20 = 20'($urandom);
    while (!done20 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd21);
    check({tag, " bcd"}, 64'(bcd20), ref_bcd(longint'(v), 7));
    check({tag, " blank"}, 64'(blank20), ref_blank(longint'(v), 7));
    $display("conv20 %s in=%0d bcd=%07h blank=%07b latency=%0d", tag, v, bcd20, blank20, cyc);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  val;
    logic [7:0]  acc;
    logic [63:0] eb;

    rst = 1'b1;
    s8 = 1'b0;  b8 = '0;
    s20 = 1'b0; b20 = '0;
    prev_bcd8 = '0;
    #1;
    check("rst busy8", 64'(busy8), 64'd0);
    check("rst done8", 64'(done8), 64'd0);
    check("rst bcd8", 64'(bcd8), 64'd0);
    check("rst blank8", 64'(blank8), 64'b110);
    check("rst blank20", 64'(blank20), 64'b1111110);
    check("rst bcd20", 64'(bcd20), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed corner values.
    conv8(8'd255, "d255");
    conv8(8'd0,   "d0");
    conv8(8'd10,  "d10");
    conv8(8'd100, "d100");
    conv20(20'd1048575, "w_max");
    conv20(20'd7,       "w_7");
    conv20(20'($urandom_range(0, 1048575)), "w_rand");

    for (int i = 0; i < 8; i++) begin
      conv8(8'($urandom_range(0, 255)), "rand");
    end

    // start held high with bin_in changing every cycle: accepts only every 10th edge.
    for (int e = 0; e < 32; e++) begin
      s8  = (e < 30);
      val = 8'($urandom);
      b8  = val;
      @(posedge clk); #1;
      if (e < 30 && (e % 10) == 0) q.push_back(val);
      check("held done", 64'(done8), 64'((e % 10) == 9));
      if (done8 && q.size() > 0) begin
        acc = q.pop_front();
        eb  = ref_bcd(longint'(acc), 3);
        check("held bcd", 64'(bcd8), eb);
        check("held blank", 64'(blank8), ref_blank(longint'(acc), 3));
        $display("held edge=%0d in=%0d bcd=%03h blank=%03b", e, acc, bcd8, blank8);
        prev_bcd8 = eb[11:0];
      end
    end
    s8 = 1'b0;

    // Reset during shift step 4 of a conversion of 200.
    s8 = 1'b1;
    b8 = 8'd200;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst busy", 64'(busy8), 64'd0);
    check("midrst done", 64'(done8), 64'd0);
    check("midrst bcd", 64'(bcd8), 64'd0);
    check("midrst blank", 64'(blank8), 64'b110);
    $display("midrst busy=%0b done=%0b bcd=%03h blank=%03b", busy8, done8, bcd8, blank8);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst no_done", 64'(done8), 64'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("postrst no_done", 64'(done8), 64'd0);
    end
    prev_bcd8 = '0;
    conv8(8'd42, "after_rst");

    // Exhaustive, back to back.
    for (int v = 0; v < 256; v++) begin
      conv8(8'(v), "exh");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
